// File: rtl/semi_auto_pkg.sv
// semi_auto_pkg: shared definitions for the semi-automatic drive sequencer.
//   - state_t       : sequencer FSM state encoding
//   - MV_*          : moving_state command codes (one-hot or zero)
//   - DET_*         : bit positions of the detector pattern, in the order the
//                     UART return byte carries them: front, left, right, back
//   - is_junction() : arrival condition evaluated on the filtered detectors
package semi_auto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN1,
        ST_TURN2,
        ST_SETTLE,
        ST_CRUISE
    } state_t;

    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_BACK  = 4'b0010;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    // Pattern is assembled as {front, left, right, back}.
    localparam int DET_FRONT = 3;
    localparam int DET_LEFT  = 2;
    localparam int DET_RIGHT = 1;
    localparam int DET_BACK  = 0;

    // A junction is reached when the way ahead is blocked or a side opens up.
    function automatic logic is_junction(input logic [3:0] det);
        return det[DET_FRONT] | ~det[DET_LEFT] | ~det[DET_RIGHT];
    endfunction

endpackage

// File: rtl/semi_auto_ctrl_det_filter.sv
// det_filter: debounces the 4-bit detector pattern returned over UART.
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   clr      in  restart the stability count (sequencer disabled)
//   raw      in  raw detector pattern {front, left, right, back}
//   filt_det out pattern latched after DET_STABLE unchanged cycles
// The filtered value resets to all-blocked so nothing moves on stale data.
module det_filter
    import semi_auto_pkg::*;
#(
    parameter int DET_STABLE = 1_000_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [3:0] raw,
    output logic [3:0] filt_det
);

    logic [3:0]       last;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 4'b1111;
            cnt      <= '0;
            filt_det <= 4'b1111;
        end else if (clr) begin
            cnt <= '0;
        end else if (raw != last) begin
            // Any change restarts the stability window.
            last <= raw;
            cnt  <= '0;
        end else if (cnt == CNT_W'(DET_STABLE - 1)) begin
            // Count saturates here; keep refreshing the filtered value.
            filt_det <= last;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/semi_auto_ctrl.sv
// semi_auto_ctrl: turns one-shot direction requests into a timed sequence of
// moving_state codes: turn(s), settle forward, cruise until the next junction.
//   sys_clk      in  system clock
//   rst          in  synchronous reset, active-high
//   enable       in  semi-auto mode selected; low aborts to IDLE
//   req_fwd/left/right/back  in  single-cycle request pulses
//   front/left/right/back_det in raw detector bits (1 = blocked)
//   moving_state out [0] fwd [1] back [2] left [3] right
//   busy         out sequence in progress
//   junction     out one-cycle pulse on arrival at a junction
//   reject       out one-cycle pulse when a forward request is refused
module semi_auto_ctrl
    import semi_auto_pkg::*;
#(
    parameter int TURN_CYCLES   = 90_000_000,
    parameter int SETTLE_CYCLES = 50_000_000,
    parameter int DET_STABLE    = 1_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req_fwd,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_back,
    input  logic       front_det,
    input  logic       left_det,
    input  logic       right_det,
    input  logic       back_det,
    output logic [3:0] moving_state,
    output logic       busy,
    output logic       junction,
    output logic       reject
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             u_turn;     // TURN1 continues into TURN2
    logic [3:0]       filt_det;
    logic             back_unused;

    det_filter #(
        .DET_STABLE (DET_STABLE),
        .CNT_W      (CNT_W)
    ) u_det_filter (
        .clk      (sys_clk),
        .rst      (rst),
        .clr      (~enable),
        .raw      ({front_det, left_det, right_det, back_det}),
        .filt_det (filt_det)
    );

    // Rear wall is tracked but no transition depends on it yet.
    assign back_unused = filt_det[DET_BACK];

    always_ff @(posedge sys_clk) begin
        if (rst || !enable) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            u_turn       <= 1'b0;
            moving_state <= MV_STOP;
            busy         <= 1'b0;
            junction     <= 1'b0;
            reject       <= 1'b0;
        end else begin
            junction <= 1'b0;
            reject   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    moving_state <= MV_STOP;
                    cnt          <= '0;
                    // Priority fwd > left > right > back; the rest are dropped.
                    if (req_fwd) begin
                        if (filt_det[DET_FRONT]) begin
                            reject <= 1'b1;
                        end else begin
                            state        <= ST_SETTLE;
                            moving_state <= MV_FWD;
                            busy         <= 1'b1;
                        end
                    end else if (req_left || req_right || req_back) begin
                        state        <= ST_TURN1;
                        moving_state <= req_right && !req_left ? MV_RIGHT : MV_LEFT;
                        u_turn       <= !req_left && !req_right;
                        busy         <= 1'b1;
                    end
                end
                ST_TURN1, ST_TURN2: begin
                    if (cnt == CNT_W'(TURN_CYCLES - 1)) begin
                        cnt <= '0;
                        if (state == ST_TURN1 && u_turn) begin
                            state        <= ST_TURN2;
                            moving_state <= MV_LEFT;
                        end else begin
                            state        <= ST_SETTLE;
                            moving_state <= MV_FWD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Detectors ignored while the car leaves the junction.
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_CRUISE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CRUISE: begin
                    if (is_junction(filt_det)) begin
                        state        <= ST_IDLE;
                        moving_state <= MV_STOP;
                        busy         <= 1'b0;
                        junction     <= 1'b1;
                        u_turn       <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    moving_state <= MV_STOP;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
